// File: rtl/df_pkg.sv
// Shared definitions for the data-forwarding datapath: address width defaults,
// scoreboard entry layout and pipeline depth bounds.
package df_pkg;

    localparam int AW_DEF    = 5;
    localparam int AW_MAX    = 8;
    localparam int DEPTH_MIN = 2;
    localparam int DEPTH_MAX = 8;

    // rd is sized for the widest supported address; narrower AW is zero-extended.
    typedef struct packed {
        logic              v;
        logic              we;
        logic [AW_MAX-1:0] rd;
    } sb_entry_t;

endpackage

// File: rtl/df_src_match.sv
// Youngest-match encoder for one source operand against the in-flight scoreboard.
// at_k1 and at_far are mutually exclusive; hit is their union.
module df_src_match
    import df_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic              use_src,
    input  logic [AW_MAX-1:0] src,
    input  sb_entry_t         sb [1:DEPTH-1],
    output logic              hit,
    output logic              at_k1,
    output logic              at_far
);

    always_comb begin
        at_k1  = use_src & sb[1].v & sb[1].we & (sb[1].rd == src);
        at_far = 1'b0;
        for (int k = 2; k < DEPTH; k++) begin
            at_far = at_far | (sb[k].v & sb[k].we & (sb[k].rd == src));
        end
        // An older match only matters when the slot-1 entry does not match.
        at_far = at_far & use_src & ~at_k1;
        hit    = at_k1 | at_far;
    end

endmodule

// File: rtl/df_hazard_ctrl.sv
// Issue-stage hazard controller: tracks in-flight destinations and decides
// issue / forward-B / stall for the instruction presented by decode.
module df_hazard_ctrl
    import df_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int AW     = AW_DEF,
    parameter bit FWD_EN = 1'b1
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          enable,
    input  logic          flush,
    input  logic          issue_valid,
    input  logic          issue_we,
    input  logic [AW-1:0] issue_rd,
    input  logic [AW-1:0] issue_ra,
    input  logic [AW-1:0] issue_rb,
    input  logic          use_ra,
    input  logic          use_rb,
    output logic          issue_accept,
    output logic          stall,
    output logic          fwd_b,
    output logic [15:0]   stall_cnt
);

    // Handshake: decode holds issue_* while stall=1; the instruction is consumed
    // on the rising edge where issue_accept=1 (valid & enable & ~flush & ~stall).

    sb_entry_t sb [1:DEPTH-1];
    sb_entry_t sb_in;

    logic ra_hit, ra_k1, ra_far;
    logic rb_hit, rb_k1, rb_far;
    logic rb_fwd, rb_haz, gate;

    df_src_match #(.DEPTH(DEPTH)) u_match_ra (
        .use_src (use_ra),
        .src     (AW_MAX'(issue_ra)),
        .sb      (sb),
        .hit     (ra_hit),
        .at_k1   (ra_k1),
        .at_far  (ra_far)
    );

    df_src_match #(.DEPTH(DEPTH)) u_match_rb (
        .use_src (use_rb),
        .src     (AW_MAX'(issue_rb)),
        .sb      (sb),
        .hit     (rb_hit),
        .at_k1   (rb_k1),
        .at_far  (rb_far)
    );

    always_comb begin
        gate         = issue_valid & enable & ~flush;
        rb_fwd       = rb_k1 & FWD_EN;
        rb_haz       = rb_far | (rb_k1 & ~FWD_EN);
        // Operand A has no feedback path, so any match on it is a hazard.
        stall        = gate & (ra_hit | rb_haz);
        issue_accept = gate & ~stall;
        fwd_b        = issue_accept & rb_fwd & rb_hit;
        sb_in.v      = issue_accept;
        sb_in.we     = issue_we;
        sb_in.rd     = AW_MAX'(issue_rd);
    end

    // Stalled or idle cycles shift in a bubble through sb_in.v.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int k = 1; k < DEPTH; k++) begin
                sb[k] <= '0;
            end
        end else if (enable) begin
            if (flush) begin
                for (int k = 1; k < DEPTH; k++) begin
                    sb[k].v <= 1'b0;
                end
            end else begin
                for (int k = DEPTH - 1; k >= 2; k--) begin
                    sb[k] <= sb[k-1];
                end
                sb[1] <= sb_in;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stall_cnt <= '0;
        end else if (stall && (stall_cnt != 16'hFFFF)) begin
            stall_cnt <= stall_cnt + 16'd1;
        end
    end

endmodule

// File: tb/tb_df_hazard_ctrl.sv
// Bench for df_hazard_ctrl: two instances (FWD_EN=0 as lane 0, FWD_EN=1 as lane 1)
// share stimulus; a per-register last-write-time model predicts every output.
module tb_df_hazard_ctrl;

    localparam int DEPTH = 4;
    localparam int AW    = 5;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          enable = 1'b0;
    logic          flush = 1'b0;
    logic          issue_valid = 1'b0;
    logic          issue_we = 1'b0;
    logic          use_ra = 1'b0;
    logic          use_rb = 1'b0;
    logic [AW-1:0] issue_rd = '0;
    logic [AW-1:0] issue_ra = '0;
    logic [AW-1:0] issue_rb = '0;

    logic          acc_o   [2];
    logic          stall_o [2];
    logic          fwd_o   [2];
    logic [15:0]   cnt_o   [2];

    int checks = 0;
    int errors = 0;

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, expected $finish earlier");
        $fatal(1);
    end

    df_hazard_ctrl #(.DEPTH(DEPTH), .AW(AW), .FWD_EN(1'b0)) dut_nofwd (
        .clk(clk), .reset_n(reset_n), .enable(enable), .flush(flush),
        .issue_valid(issue_valid), .issue_we(issue_we), .issue_rd(issue_rd),
        .issue_ra(issue_ra), .issue_rb(issue_rb), .use_ra(use_ra), .use_rb(use_rb),
        .issue_accept(acc_o[0]), .stall(stall_o[0]), .fwd_b(fwd_o[0]), .stall_cnt(cnt_o[0])
    );

    df_hazard_ctrl #(.DEPTH(DEPTH), .AW(AW), .FWD_EN(1'b1)) dut_fwd (
        .clk(clk), .reset_n(reset_n), .enable(enable), .flush(flush),
        .issue_valid(issue_valid), .issue_we(issue_we), .issue_rd(issue_rd),
        .issue_ra(issue_ra), .issue_rb(issue_rb), .use_ra(use_ra), .use_rb(use_rb),
        .issue_accept(acc_o[1]), .stall(stall_o[1]), .fwd_b(fwd_o[1]), .stall_cnt(cnt_o[1])
    );

    // ---------------- reference model ----------------
    // lw_time[f][r] = enabled-shift count at which r was last written by an accepted
    // instruction; the youngest producer distance is simply now - lw_time.
    bit lw_valid  [2][32];
    int lw_time   [2][32];
    int ecnt      [2];
    int mcnt      [2];
    bit exp_acc   [2];
    bit exp_stall [2];
    bit exp_fwd   [2];

    function automatic int dist_of(int f, logic [AW-1:0] r);
        if (lw_valid[f][r] && (ecnt[f] - lw_time[f][r]) < DEPTH)
            return ecnt[f] - lw_time[f][r];
        return 0;
    endfunction

    task automatic model_reset();
        for (int f = 0; f < 2; f++) begin
            for (int r = 0; r < 32; r++) lw_valid[f][r] = 1'b0;
            ecnt[f] = 0;
            mcnt[f] = 0;
        end
    endtask

    task automatic model_eval();
        for (int f = 0; f < 2; f++) begin
            bit gate, haz;
            int da, db;
            gate = issue_valid && enable && !flush;
            da   = use_ra ? dist_of(f, issue_ra) : 0;
            db   = use_rb ? dist_of(f, issue_rb) : 0;
            haz  = (da != 0) || (db >= 2) || (db == 1 && f == 0);
            exp_stall[f] = gate && haz;
            exp_acc[f]   = gate && !haz;
            exp_fwd[f]   = exp_acc[f] && (db == 1) && (f == 1);
        end
    endtask

    task automatic model_clock();
        for (int f = 0; f < 2; f++) begin
            if (enable) begin
                if (flush) begin
                    for (int r = 0; r < 32; r++) lw_valid[f][r] = 1'b0;
                end else begin
                    if (exp_acc[f] && issue_we) begin
                        lw_valid[f][issue_rd] = 1'b1;
                        lw_time[f][issue_rd]  = ecnt[f];
                    end
                    ecnt[f]++;
                end
            end
            if (exp_stall[f] && mcnt[f] != 65535) mcnt[f]++;
        end
    endtask

    // ---------------- scoreboard helpers ----------------
    task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Check all outputs of both lanes against the model at the falling edge,
    // then advance the model with the rising edge.
    task automatic tick();
        @(negedge clk);
        model_eval();
        for (int f = 0; f < 2; f++) begin
            cmp($sformatf("lane%0d accept", f), 32'(acc_o[f]), 32'(exp_acc[f]));
            cmp($sformatf("lane%0d stall", f), 32'(stall_o[f]), 32'(exp_stall[f]));
            cmp($sformatf("lane%0d fwd_b", f), 32'(fwd_o[f]), 32'(exp_fwd[f]));
            cmp($sformatf("lane%0d stall_cnt", f), 32'(cnt_o[f]), 32'(mcnt[f]));
        end
        @(posedge clk);
        model_clock();
        #1;
    endtask

    // ---------------- driver tasks ----------------
    task automatic drive(input logic v, input logic we, input logic [4:0] rd,
                         input logic [4:0] ra, input logic [4:0] rb,
                         input logic ua, input logic ub, input logic en, input logic fl);
        issue_valid = v;  issue_we = we;  issue_rd = rd;
        issue_ra = ra;    issue_rb = rb;  use_ra = ua;  use_rb = ub;
        enable = en;      flush = fl;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        drive(1'b1, 1'b1, 5'd0, 5'd0, 5'd0, 1'b1, 1'b1, 1'b1, 1'b0);
        @(posedge clk);
        #1;
        for (int f = 0; f < 2; f++) begin
            cmp($sformatf("reset lane%0d accept", f), 32'(acc_o[f]), 32'd1);
            cmp($sformatf("reset lane%0d stall", f), 32'(stall_o[f]), 32'd0);
            cmp($sformatf("reset lane%0d fwd_b", f), 32'(fwd_o[f]), 32'd0);
            cmp($sformatf("reset lane%0d stall_cnt", f), 32'(cnt_o[f]), 32'd0);
        end
        drive(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
        model_reset();
        reset_n = 1'b1;
    endtask

    // Present the current instruction until each lane accepts it (bounded),
    // counting stall cycles per lane before its first acceptance.
    task automatic run_dep(output int s0, output int s1, output logic f1_acc);
        bit done [2];
        int s [2];
        done[0] = 1'b0; done[1] = 1'b0; s[0] = 0; s[1] = 0; f1_acc = 1'b0;
        for (int i = 0; i < 6; i++) begin
            #1;
            for (int f = 0; f < 2; f++) begin
                if (!done[f]) begin
                    if (stall_o[f]) s[f]++;
                    else if (acc_o[f]) begin
                        done[f] = 1'b1;
                        if (f == 1) f1_acc = fwd_o[1];
                    end
                end
            end
            tick();
        end
        s0 = s[0];
        s1 = s[1];
    endtask

    // ---------------- directed table (expectations for lane 1, FWD_EN=1) ----------------
    typedef struct {
        logic v, we;
        logic [4:0] rd, ra, rb;
        logic ua, ub, en, fl;
        logic ea, es, ef;
        logic [15:0] ec;
    } vec_t;

    vec_t vecs[$];
    logic [18:0] exp_q[$];

    task automatic add(input logic v, input logic we, input logic [4:0] rd,
                       input logic [4:0] ra, input logic [4:0] rb,
                       input logic ua, input logic ub, input logic en, input logic fl,
                       input logic ea, input logic es, input logic ef, input logic [15:0] ec);
        vec_t t;
        t.v = v; t.we = we; t.rd = rd; t.ra = ra; t.rb = rb;
        t.ua = ua; t.ub = ub; t.en = en; t.fl = fl;
        t.ea = ea; t.es = es; t.ef = ef; t.ec = ec;
        vecs.push_back(t);
    endtask

    initial begin
        int s0, s1;
        logic f1;
        logic [18:0] e;

        //  v  we rd  ra  rb  ua ub en fl   acc st fw cnt
        add(1, 1, 1,  2,  3,  1, 1, 1, 0,   1, 0, 0, 0);   // independent stream
        add(1, 1, 4,  5,  6,  1, 1, 1, 0,   1, 0, 0, 0);
        add(1, 1, 2,  0,  7,  1, 1, 1, 0,   1, 0, 0, 0);
        add(1, 1, 9,  8,  2,  1, 1, 1, 0,   1, 0, 1, 0);   // RB distance 1: forward
        add(1, 1, 10, 2,  0,  1, 0, 1, 0,   0, 1, 0, 0);   // RA distance 2
        add(1, 1, 10, 2,  0,  1, 0, 1, 0,   0, 1, 0, 1);
        add(1, 1, 10, 2,  0,  1, 0, 1, 0,   1, 0, 0, 2);
        add(0, 0, 0,  0,  0,  0, 0, 1, 0,   0, 0, 0, 2);   // idle bubble
        add(1, 1, 12, 0,  10, 0, 1, 1, 0,   0, 1, 0, 2);   // RB distance 2
        add(1, 1, 12, 0,  10, 0, 1, 1, 0,   0, 1, 0, 3);
        add(1, 1, 12, 0,  10, 0, 1, 1, 0,   1, 0, 0, 4);
        add(1, 0, 5,  0,  0,  0, 0, 1, 0,   1, 0, 0, 4);   // no write-enable
        add(1, 1, 13, 5,  0,  1, 0, 1, 0,   1, 0, 0, 4);
        add(1, 1, 14, 13, 0,  1, 0, 1, 1,   0, 0, 0, 4);   // flush beats issue
        add(1, 1, 15, 13, 0,  1, 0, 1, 0,   1, 0, 0, 4);
        add(1, 1, 16, 15, 0,  1, 0, 0, 0,   0, 0, 0, 4);   // enable low
        add(1, 1, 16, 15, 0,  1, 0, 1, 0,   0, 1, 0, 4);
        add(1, 1, 16, 15, 0,  1, 0, 1, 0,   0, 1, 0, 5);
        add(1, 1, 16, 15, 0,  1, 0, 1, 0,   0, 1, 0, 6);
        add(1, 1, 16, 15, 0,  1, 0, 1, 0,   1, 0, 0, 7);
        add(1, 1, 20, 0,  0,  0, 0, 1, 0,   1, 0, 0, 7);   // youngest match decides
        add(1, 1, 20, 0,  0,  0, 0, 1, 0,   1, 0, 0, 7);
        add(1, 1, 21, 0,  20, 0, 1, 1, 0,   1, 0, 1, 7);
        add(1, 1, 22, 20, 0,  1, 0, 1, 0,   0, 1, 0, 7);
        add(0, 0, 0,  0,  0,  0, 0, 1, 0,   0, 0, 0, 8);
        add(1, 1, 0,  1,  1,  0, 0, 1, 0,   1, 0, 0, 8);   // register 0 tracked
        add(1, 1, 23, 0,  0,  1, 0, 1, 0,   0, 1, 0, 8);
        add(0, 0, 0,  0,  0,  0, 0, 1, 0,   0, 0, 0, 9);
        add(1, 1, 17, 0,  0,  0, 0, 1, 0,   1, 0, 0, 9);   // freeze during stall
        add(1, 1, 24, 17, 0,  1, 0, 1, 0,   0, 1, 0, 9);
        for (int i = 0; i < 5; i++)
            add(1, 1, 24, 17, 0,  1, 0, 0, 0,   0, 0, 0, 10);
        add(1, 1, 24, 17, 0,  1, 0, 1, 0,   0, 1, 0, 10);
        add(1, 1, 24, 17, 0,  1, 0, 1, 0,   0, 1, 0, 11);
        add(1, 1, 24, 17, 0,  1, 0, 1, 0,   1, 0, 0, 12);

        do_reset();

        foreach (vecs[i]) begin
            drive(vecs[i].v, vecs[i].we, vecs[i].rd, vecs[i].ra, vecs[i].rb,
                  vecs[i].ua, vecs[i].ub, vecs[i].en, vecs[i].fl);
            exp_q.push_back({vecs[i].ea, vecs[i].es, vecs[i].ef, vecs[i].ec});
            #2;
            e = exp_q.pop_front();
            cmp($sformatf("vec%0d accept", i), 32'(acc_o[1]), 32'(e[18]));
            cmp($sformatf("vec%0d stall", i), 32'(stall_o[1]), 32'(e[17]));
            cmp($sformatf("vec%0d fwd_b", i), 32'(fwd_o[1]), 32'(e[16]));
            cmp($sformatf("vec%0d stall_cnt", i), 32'(cnt_o[1]), 32'(e[15:0]));
            tick();
        end

        // Asynchronous reset in the middle of a stall.
        drive(1, 1, 18, 0, 0, 0, 0, 1, 0);
        tick();
        drive(1, 1, 25, 18, 0, 1, 0, 1, 0);
        #2;
        cmp("pre-reset stall", 32'(stall_o[1]), 32'd1);
        reset_n = 1'b0;
        #1;
        model_reset();
        for (int f = 0; f < 2; f++) begin
            cmp($sformatf("midrst lane%0d stall", f), 32'(stall_o[f]), 32'd0);
            cmp($sformatf("midrst lane%0d stall_cnt", f), 32'(cnt_o[f]), 32'd0);
            cmp($sformatf("midrst lane%0d accept", f), 32'(acc_o[f]), 32'd1);
        end
        reset_n = 1'b1;
        tick();

        // Distance-2 dependency on RB: two stall cycles whether or not forwarding exists.
        do_reset();
        drive(1, 1, 3, 0, 0, 0, 0, 1, 0);
        tick();
        drive(1, 1, 4, 0, 0, 1, 0, 1, 0);
        tick();
        drive(1, 1, 5, 0, 3, 0, 1, 1, 0);
        run_dep(s0, s1, f1);
        cmp("dist2 lane0 stalls", 32'(s0), 32'd2);
        cmp("dist2 lane1 stalls", 32'(s1), 32'd2);

        // Distance-1 dependency on RB: forwarded with FWD_EN=1, three stalls without.
        do_reset();
        drive(1, 1, 3, 0, 0, 0, 0, 1, 0);
        tick();
        drive(1, 1, 5, 0, 3, 0, 1, 1, 0);
        run_dep(s0, s1, f1);
        cmp("dist1 lane0 stalls", 32'(s0), 32'd3);
        cmp("dist1 lane1 stalls", 32'(s1), 32'd0);
        cmp("dist1 lane1 fwd_b", 32'(f1), 32'd1);
        cmp("dist1 lane0 stall_cnt", 32'(cnt_o[0]), 32'd3);

        // Randomized traffic over a small register set to provoke frequent matches.
        do_reset();
        for (int i = 0; i < 600; i++) begin
            drive(logic'($urandom_range(0, 9) < 8), logic'($urandom_range(0, 9) < 7),
                  5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                  logic'($urandom_range(0, 1)), logic'($urandom_range(0, 1)),
                  logic'($urandom_range(0, 19) < 17), logic'($urandom_range(0, 24) == 0));
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/df_hazard_ctrl.md
# df_hazard_ctrl

Issue-stage hazard controller for the IPPro datapath. It keeps a scoreboard of destination registers for in-flight instructions. Before each instruction enters the DSP48-based execute pipeline, it decides whether the instruction issues, forwards operand B through the P-feedback path, or stalls. It sits between instruction decode and the data-forwarding opmode logic, and its FWD_B output drives that logic's forward-select.

## Interface
- DEPTH, 4: cycles from issue until a result is readable from the register file; legal range 2..8.
- AW, 5: register address width.
- FWD_EN, 1: 1 enables distance-1 forwarding on operand B; 0 turns every distance-1 B dependency into a stall.
- CLK  in  1  clock; all state changes on the rising edge.
- RESET_N  in  1  asynchronous active-low reset.
- ENABLE  in  1  global pipeline advance; 0 freezes all state.
- FLUSH  in  1  synchronous clear of the scoreboard.
- ISSUE_VALID  in  1  decode presents an instruction.
- ISSUE_WE  in  1  the instruction writes ISSUE_RD.
- ISSUE_RD  in  AW  destination register.
- ISSUE_RA, ISSUE_RB  in  AW each  source registers.
- USE_RA, USE_RB  in  1 each  the source is actually read.
- ISSUE_ACCEPT  out  1  the instruction is taken this cycle.
- STALL  out  1  a hazard is holding the presented instruction.
- FWD_B  out  1  the accepted instruction takes operand B from P feedback.
- STALL_CNT  out  16  saturating count of stall cycles.

## Operation
- Scoreboard SB[1..DEPTH-1], one entry per slot, each entry {v, we, rd}. SB[k] holds the instruction accepted k enabled cycles ago.
- Match for source S at slot k: USE_S & SB[k].v & SB[k].we & (SB[k].rd == S). Register 0 gets no special treatment.
- For each source, the youngest (lowest-k) match decides the outcome. Older matches are ignored.
- RA hazard: any match at any k.
- RB result:
  - Youngest match at k=1 with FWD_EN=1: forward.
  - Youngest match at k=1 with FWD_EN=0: hazard.
  - Youngest match at k≥2: hazard.
  - No match: register file read.
- STALL = ISSUE_VALID & ENABLE & ~FLUSH & (RA hazard | RB hazard).
- ISSUE_ACCEPT = ISSUE_VALID & ENABLE & ~FLUSH & ~STALL.
- FWD_B = ISSUE_ACCEPT & (RB result is forward). FWD_B is 0 whenever the instruction is not accepted.
- Shift on each rising edge with ENABLE=1 and FLUSH=0:
  - SB[k+1] <= SB[k].
  - SB[1] <= {ISSUE_ACCEPT, ISSUE_WE, ISSUE_RD}.
  - A stall or an idle cycle therefore inserts a bubble (v=0).
- FLUSH=1 with ENABLE=1: all v cleared. FLUSH wins over a simultaneous issue, which is not accepted and not counted.
- ENABLE=0: SB and STALL_CNT hold; ISSUE_ACCEPT, STALL and FWD_B are all 0.
- STALL_CNT increments on each edge where STALL=1 and saturates at 0xFFFF.

## Timing
- Reset (RESET_N=0, asynchronous): all SB.v=0 and STALL_CNT=0. Outputs are therefore ISSUE_ACCEPT=ISSUE_VALID&ENABLE&~FLUSH, STALL=0, FWD_B=0.
- Reset mid-operation drops all in-flight tracking immediately, with no completion of pending entries.
- ISSUE_ACCEPT, STALL and FWD_B are combinational from the current inputs and SB. There is no registered output delay.
- An instruction accepted at cycle t is visible to hazard checks from cycle t+1. It is invisible from t+DEPTH, when the register file write-first path covers it.
- Worst-case stall for a dependent instruction is DEPTH-1 cycles. A stalled instruction is re-evaluated every enabled cycle as the bubbles shift.
- Decode must hold ISSUE_* stable while STALL=1.

## Structure
- Shared package df_pkg holds:
  - the AW default;
  - the scoreboard entry struct {v, we, rd};
  - the DEPTH bounds constants, also used by the DF opmode logic.
- One sub-module, df_src_match: per-source youngest-match encoder over SB. It outputs {hit, k==1, k≥2} and is instantiated once for RA and once for RB.
- STALL_CNT and the bubble logic stay in the top level.

## Test plan
- Reset then an independent stream (RD=1, RA=2, RB=3; then RD=4, RA=5, RB=6) -> ACCEPT=1 each cycle, STALL=0, FWD_B=0, STALL_CNT=0.
- Back-to-back RD=2 then RB=2 (USE_RB=1, DEPTH=4, FWD_EN=1) -> second instruction accepted with FWD_B=1, no stall.
- Back-to-back RD=2 then RA=2 -> STALL=1 for 3 cycles, then accept on the 4th. STALL_CNT=3.
- RD=3, then an unrelated instruction, then RB=3 (distance 2) -> 2 stall cycles. Repeat with FWD_EN=0 at distance 1 -> 3 stall cycles.
- FLUSH asserted on the cycle after RD=2, with RA=2 presented -> that issue is not accepted. On the next cycle RA=2 is accepted with no stall.
- ENABLE=0 for 5 cycles while a hazard is pending -> STALL=0, STALL_CNT unchanged. After ENABLE=1 returns, the remaining stall count matches the no-freeze case. Async RESET_N pulse mid-stall -> STALL drops immediately and STALL_CNT=0.
